// File: rtl/lsu_store_queue.sv
// lsu_store_queue: committed-store buffer sitting between commit and the
// DCache write port. Stores enter in program order, drain one at a time via a
// request/ack handshake, and supply byte-merged forwarding to the load pipe.
// Entries leave only by draining; nothing is flushed short of reset.
`timescale 1ns/1ps

module lsu_store_queue #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq_valid_i,
  output logic                          enq_ready_o,
  input  logic [ADDR_WIDTH-1:0]         enq_addr_i,
  input  logic [DATA_WIDTH-1:0]         enq_data_i,
  input  logic [DATA_WIDTH/8-1:0]       enq_wstrb_i,
  output logic                          dc_req_valid_o,
  input  logic                          dc_req_ready_i,
  output logic [ADDR_WIDTH-1:0]         dc_addr_o,
  output logic [DATA_WIDTH-1:0]         dc_data_o,
  output logic [DATA_WIDTH/8-1:0]       dc_wstrb_o,
  input  logic                          dc_resp_valid_i,
  input  logic [ADDR_WIDTH-1:0]         fwd_addr_i,
  output logic [DATA_WIDTH-1:0]         fwd_data_o,
  output logic [DATA_WIDTH/8-1:0]       fwd_mask_o,
  output logic                          empty_o,
  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PTR_W  = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [PTR_W-1:0]        head_q, head_d;
  logic [PTR_W-1:0]        tail_q, tail_d;
  logic [DEPTH-1:0]        valid_q;
  logic [ADDR_WIDTH-1:0]   addr_q [DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [DEPTH];
  logic [STRB_W-1:0]       strb_q [DEPTH];

  logic                    full_s;
  logic                    empty_s;
  logic                    enq_fire_s;
  logic                    pop_s;
  logic [IDX_W-1:0]        head_idx_s;
  logic [IDX_W-1:0]        tail_idx_s;
  logic [IDX_W-1:0]        scan_idx_s;
  logic [DATA_WIDTH-1:0]   fwd_data_s;
  logic [STRB_W-1:0]       fwd_mask_s;
  logic                    fwd_addr_unused_s;

  // Word-granular forwarding match ignores the byte offset bits.
  assign fwd_addr_unused_s = &{1'b0, fwd_addr_i[1:0]};

  assign head_idx_s = head_q[IDX_W-1:0];
  assign tail_idx_s = tail_q[IDX_W-1:0];
  assign full_s     = (head_idx_s == tail_idx_s) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign empty_s    = (head_q == tail_q);
  // Ready looks at full only, so a same-cycle pop never lets a store in early.
  assign enq_fire_s = enq_valid_i & ~full_s;
  assign pop_s      = (state_q == ST_WAIT) & dc_resp_valid_i;

  assign enq_ready_o    = ~full_s;
  assign empty_o        = empty_s;
  assign count_o        = tail_q - head_q;
  assign dc_req_valid_o = (state_q == ST_REQ);
  assign dc_addr_o      = (state_q == ST_REQ) ? addr_q[head_idx_s] : {ADDR_WIDTH{1'b0}};
  assign dc_data_o      = (state_q == ST_REQ) ? data_q[head_idx_s] : {DATA_WIDTH{1'b0}};
  assign dc_wstrb_o     = (state_q == ST_REQ) ? strb_q[head_idx_s] : {STRB_W{1'b0}};
  assign fwd_data_o     = fwd_data_s;
  assign fwd_mask_o     = fwd_mask_s;

  // Drain FSM next state: fetch head, hold request until accepted, await ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (!empty_s) state_d = ST_REQ;
        else          state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (dc_req_ready_i) state_d = ST_WAIT;
        else                state_d = ST_REQ;
      end
      ST_WAIT: begin
        if (dc_resp_valid_i) state_d = ST_IDLE;
        else                 state_d = ST_WAIT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer next state: tail advances on accept, head on write ack.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_s) head_d = head_q + PTR_W'(1);
    else       head_d = head_q;
    if (enq_fire_s) tail_d = tail_q + PTR_W'(1);
    else            tail_d = tail_q;
  end

  // FSM state and queue pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  // Entry storage: write at tail on accept, retire head valid bit on ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_WIDTH{1'b0}};
        data_q[i] <= {DATA_WIDTH{1'b0}};
        strb_q[i] <= {STRB_W{1'b0}};
      end
    end else begin
      if (enq_fire_s) begin
        valid_q[tail_idx_s] <= 1'b1;
        addr_q[tail_idx_s]  <= enq_addr_i;
        data_q[tail_idx_s]  <= enq_data_i;
        strb_q[tail_idx_s]  <= enq_wstrb_i;
      end
      if (pop_s) begin
        valid_q[head_idx_s] <= 1'b0;
      end
    end
  end

  // Forwarding: scan oldest to youngest so younger matching bytes overwrite.
  always_comb begin
    fwd_data_s = {DATA_WIDTH{1'b0}};
    fwd_mask_s = {STRB_W{1'b0}};
    scan_idx_s = {IDX_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx_s = head_idx_s + IDX_W'(k);
      if (valid_q[scan_idx_s] &&
          (addr_q[scan_idx_s][ADDR_WIDTH-1:2] == fwd_addr_i[ADDR_WIDTH-1:2])) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (strb_q[scan_idx_s][b]) begin
            fwd_data_s[b*8 +: 8] = data_q[scan_idx_s][b*8 +: 8];
            fwd_mask_s[b]        = 1'b1;
          end else begin
            fwd_mask_s[b] = fwd_mask_s[b];
          end
        end
      end else begin
        fwd_mask_s = fwd_mask_s;
      end
    end
  end

endmodule

// File: tb/tb_lsu_store_queue.sv
// Directed self-checking bench for lsu_store_queue.
`timescale 1ns/1ps

module tb_lsu_store_queue;

  logic        clk;
  logic        rst;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [31:0] enq_addr_i;
  logic [31:0] enq_data_i;
  logic [3:0]  enq_wstrb_i;
  logic        dc_req_valid_o;
  logic        dc_req_ready_i;
  logic [31:0] dc_addr_o;
  logic [31:0] dc_data_o;
  logic [3:0]  dc_wstrb_o;
  logic        dc_resp_valid_i;
  logic [31:0] fwd_addr_i;
  logic [31:0] fwd_data_o;
  logic [3:0]  fwd_mask_o;
  logic        empty_o;
  logic [2:0]  count_o;

  int total;
  int bad;

  lsu_store_queue #(.DEPTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid_i(enq_valid_i), .enq_ready_o(enq_ready_o),
    .enq_addr_i(enq_addr_i), .enq_data_i(enq_data_i), .enq_wstrb_i(enq_wstrb_i),
    .dc_req_valid_o(dc_req_valid_o), .dc_req_ready_i(dc_req_ready_i),
    .dc_addr_o(dc_addr_o), .dc_data_o(dc_data_o), .dc_wstrb_o(dc_wstrb_o),
    .dc_resp_valid_i(dc_resp_valid_i),
    .fwd_addr_i(fwd_addr_i), .fwd_data_o(fwd_data_o), .fwd_mask_o(fwd_mask_o),
    .empty_o(empty_o), .count_o(count_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq_one(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    enq_valid_i = 1'b1;
    enq_addr_i  = a;
    enq_data_i  = d;
    enq_wstrb_i = s;
    tick();
    enq_valid_i = 1'b0;
  endtask

  // Waits (bounded) for a request, captures payload, handshakes and acks.
  task automatic drain_one(input bit enq_at_pop, output logic [31:0] a,
                           output logic [31:0] d, output logic [3:0] s, output bit to);
    int n;
    n  = 0;
    to = 1'b0;
    while (dc_req_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (dc_req_valid_o !== 1'b1) to = 1'b1;
    a = dc_addr_o;
    d = dc_data_o;
    s = dc_wstrb_o;
    dc_req_ready_i = 1'b1;
    tick();
    dc_req_ready_i = 1'b0;
    if (enq_at_pop) enq_valid_i = 1'b1;
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    enq_valid_i     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (enq_ready_o !== 1'b1 || dc_req_valid_o !== 1'b0 || empty_o !== 1'b1 ||
        count_o !== 3'd0) begin
      bad++;
      $display("FAIL reset_ctrl: ready=%b req=%b empty=%b count=%0d want 1 0 1 0",
               enq_ready_o, dc_req_valid_o, empty_o, count_o);
    end
    total++;
    if (dc_addr_o !== 32'h0 || dc_data_o !== 32'h0 || dc_wstrb_o !== 4'h0 ||
        fwd_mask_o !== 4'h0 || fwd_data_o !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: addr=%h data=%h strb=%h fmask=%h fdata=%h want all 0",
               dc_addr_o, dc_data_o, dc_wstrb_o, fwd_mask_o, fwd_data_o);
    end
  endtask

  task automatic test_single_store();
    dc_req_ready_i = 1'b1;
    enq_one(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
    total++;
    if (count_o !== 3'd1 || empty_o !== 1'b0 || dc_req_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL single_accept: count=%0d empty=%b req=%b want 1 0 0",
               count_o, empty_o, dc_req_valid_o);
    end
    tick();
    total++;
    if (dc_req_valid_o !== 1'b1 || dc_addr_o !== 32'h0000_1000 ||
        dc_data_o !== 32'hDEAD_BEEF || dc_wstrb_o !== 4'hF) begin
      bad++;
      $display("FAIL single_req: req=%b addr=%h data=%h strb=%h want 1 00001000 deadbeef f",
               dc_req_valid_o, dc_addr_o, dc_data_o, dc_wstrb_o);
    end
    tick();
    dc_req_ready_i = 1'b0;
    total++;
    if (dc_req_valid_o !== 1'b0 || count_o !== 3'd1) begin
      bad++;
      $display("FAIL single_wait: req=%b count=%0d want 0 1", dc_req_valid_o, count_o);
    end
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    total++;
    if (empty_o !== 1'b1 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL single_done: empty=%b count=%0d want 1 0", empty_o, count_o);
    end
  endtask

  task automatic test_fill_drain();
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          to;
    dc_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) enq_one(32'h3000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1), 4'hF);
    total++;
    if (count_o !== 3'd4 || enq_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL fill_full: count=%0d ready=%b want 4 0", count_o, enq_ready_o);
    end
    enq_one(32'h4000, 32'h5555_5555, 4'hF);
    total++;
    if (count_o !== 3'd4) begin
      bad++;
      $display("FAIL fill_held: count=%0d want 4", count_o);
    end
    for (int i = 0; i < 4; i++) begin
      drain_one(1'b0, a, d, s, to);
      total++;
      if (to || a !== 32'h3000 + 32'(4 * i) || d !== 32'h1111_1111 * 32'(i + 1)) begin
        bad++;
        $display("FAIL drain_order[%0d]: timeout=%0d addr=%h data=%h want %h %h", i, to, a, d,
                 32'h3000 + 32'(4 * i), 32'h1111_1111 * 32'(i + 1));
      end
    end
    total++;
    if (count_o !== 3'd0 || empty_o !== 1'b1) begin
      bad++;
      $display("FAIL drain_empty: count=%0d empty=%b want 0 1", count_o, empty_o);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          to;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h0000_00AA;
    exp_d[1] = 32'h0000_BB00;
    exp_d[2] = 32'h0000_00CC;
    exp_d[3] = 32'hDD00_0000;
    dc_req_ready_i = 1'b0;
    enq_one(32'h2000, 32'h0000_00AA, 4'h1);
    enq_one(32'h2000, 32'h0000_BB00, 4'h2);
    fwd_addr_i = 32'h2002;
    #1;
    total++;
    if (fwd_mask_o !== 4'h3 || fwd_data_o[15:0] !== 16'hBBAA) begin
      bad++;
      $display("FAIL fwd_merge: mask=%h data=%h want 3 xxxxbbaa", fwd_mask_o, fwd_data_o);
    end
    enq_one(32'h2000, 32'h0000_00CC, 4'h1);
    total++;
    if (fwd_mask_o !== 4'h3 || fwd_data_o[15:0] !== 16'hBBCC) begin
      bad++;
      $display("FAIL fwd_youngest: mask=%h data=%h want 3 xxxxbbcc", fwd_mask_o, fwd_data_o);
    end
    fwd_addr_i = 32'h2004;
    #1;
    total++;
    if (fwd_mask_o !== 4'h0) begin
      bad++;
      $display("FAIL fwd_miss: mask=%h want 0", fwd_mask_o);
    end
    fwd_addr_i  = 32'h2000;
    enq_valid_i = 1'b1;
    enq_addr_i  = 32'h2000;
    enq_data_i  = 32'hDD00_0000;
    enq_wstrb_i = 4'h8;
    #1;
    total++;
    if (fwd_mask_o !== 4'h3) begin
      bad++;
      $display("FAIL fwd_no_bypass: mask=%h want 3", fwd_mask_o);
    end
    tick();
    enq_valid_i = 1'b0;
    total++;
    if (fwd_mask_o !== 4'hB || fwd_data_o !== 32'hDD00_BBCC) begin
      bad++;
      $display("FAIL fwd_after_enq: mask=%h data=%h want b dd00bbcc", fwd_mask_o, fwd_data_o);
    end
    for (int i = 0; i < 4; i++) begin
      drain_one(1'b0, a, d, s, to);
      total++;
      if (to || a !== 32'h2000 || d !== exp_d[i]) begin
        bad++;
        $display("FAIL fwd_drain[%0d]: timeout=%0d addr=%h data=%h want 00002000 %h",
                 i, to, a, d, exp_d[i]);
      end
    end
  endtask

  task automatic test_full_pop_enq();
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          to;
    logic [31:0] exp_d [3];
    exp_d[0] = 32'hA3;
    exp_d[1] = 32'hB4;
    exp_d[2] = 32'hC5;
    dc_req_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) enq_one(32'h5000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
    enq_valid_i = 1'b1;
    enq_addr_i  = 32'h5100;
    enq_data_i  = 32'hB4;
    enq_wstrb_i = 4'hF;
    total++;
    if (enq_ready_o !== 1'b0 || dc_req_valid_o !== 1'b1 || dc_addr_o !== 32'h5000) begin
      bad++;
      $display("FAIL full_state: ready=%b req=%b addr=%h want 0 1 00005000",
               enq_ready_o, dc_req_valid_o, dc_addr_o);
    end
    dc_req_ready_i = 1'b1;
    tick();
    dc_req_ready_i  = 1'b0;
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    total++;
    if (count_o !== 3'd3 || enq_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL full_pop_no_bypass: count=%0d ready=%b want 3 1", count_o, enq_ready_o);
    end
    tick();
    enq_valid_i = 1'b0;
    total++;
    if (count_o !== 3'd4) begin
      bad++;
      $display("FAIL full_refill: count=%0d want 4", count_o);
    end
    drain_one(1'b0, a, d, s, to);
    total++;
    if (to || d !== 32'hA1 || count_o !== 3'd3) begin
      bad++;
      $display("FAIL pop_a1: timeout=%0d data=%h count=%0d want a1 3", to, d, count_o);
    end
    enq_addr_i = 32'h5200;
    enq_data_i = 32'hC5;
    drain_one(1'b1, a, d, s, to);
    total++;
    if (to || d !== 32'hA2 || count_o !== 3'd3) begin
      bad++;
      $display("FAIL pop_enq_same: timeout=%0d data=%h count=%0d want a2 3", to, d, count_o);
    end
    for (int i = 0; i < 3; i++) begin
      drain_one(1'b0, a, d, s, to);
      total++;
      if (to || d !== exp_d[i]) begin
        bad++;
        $display("FAIL full_drain[%0d]: timeout=%0d data=%h want %h", i, to, d, exp_d[i]);
      end
    end
    total++;
    if (empty_o !== 1'b1) begin
      bad++;
      $display("FAIL full_final_empty: empty=%b want 1", empty_o);
    end
  endtask

  task automatic test_reset_mid_drain();
    dc_req_ready_i = 1'b0;
    enq_one(32'h8000, 32'h0000_0077, 4'hF);
    tick();
    total++;
    if (dc_req_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_req_pre: req=%b want 1", dc_req_valid_o);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (dc_req_valid_o !== 1'b0 || count_o !== 3'd0) begin
      bad++;
      $display("FAIL rst_in_req: req=%b count=%0d want 0 0", dc_req_valid_o, count_o);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) enq_one(32'h7000 + 32'(4 * i), 32'h70 + 32'(i), 4'hF);
    dc_req_ready_i = 1'b1;
    tick();
    dc_req_ready_i = 1'b0;
    total++;
    if (dc_req_valid_o !== 1'b0 || count_o !== 3'd3) begin
      bad++;
      $display("FAIL rst_wait_pre: req=%b count=%0d want 0 3", dc_req_valid_o, count_o);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (dc_req_valid_o !== 1'b0 || count_o !== 3'd0 || empty_o !== 1'b1 ||
        enq_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL rst_in_wait: req=%b count=%0d empty=%b ready=%b want 0 0 1 1",
               dc_req_valid_o, count_o, empty_o, enq_ready_o);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    dc_resp_valid_i = 1'b1;
    tick();
    dc_resp_valid_i = 1'b0;
    fwd_addr_i = 32'h7000;
    tick();
    total++;
    if (dc_req_valid_o !== 1'b0 || count_o !== 3'd0 || empty_o !== 1'b1 ||
        fwd_mask_o !== 4'h0) begin
      bad++;
      $display("FAIL rst_late_resp: req=%b count=%0d empty=%b fmask=%h want 0 0 1 0",
               dc_req_valid_o, count_o, empty_o, fwd_mask_o);
    end
  endtask

  task automatic test_req_stable();
    logic [31:0] a, d;
    logic [3:0]  s;
    bit          to;
    int          n;
    dc_req_ready_i = 1'b0;
    enq_one(32'h6000, 32'h1234_5678, 4'h6);
    n = 0;
    while (dc_req_valid_o !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dc_req_valid_o !== 1'b1 || dc_addr_o !== 32'h6000 || dc_data_o !== 32'h1234_5678 ||
          dc_wstrb_o !== 4'h6) begin
        bad++;
        $display("FAIL req_stable[%0d]: req=%b addr=%h data=%h strb=%h want 1 00006000 12345678 6",
                 i, dc_req_valid_o, dc_addr_o, dc_data_o, dc_wstrb_o);
      end
      tick();
    end
    drain_one(1'b0, a, d, s, to);
    total++;
    if (to || a !== 32'h6000 || d !== 32'h1234_5678 || s !== 4'h6 || empty_o !== 1'b1) begin
      bad++;
      $display("FAIL req_stable_done: timeout=%0d addr=%h data=%h strb=%h empty=%b",
               to, a, d, s, empty_o);
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    rst             = 1'b1;
    enq_valid_i     = 1'b0;
    enq_addr_i      = 32'h0;
    enq_data_i      = 32'h0;
    enq_wstrb_i     = 4'h0;
    dc_req_ready_i  = 1'b0;
    dc_resp_valid_i = 1'b0;
    fwd_addr_i      = 32'h0;
    test_reset();
    test_single_store();
    test_fill_drain();
    test_forwarding();
    test_full_pop_enq();
    test_reset_mid_drain();
    test_req_stable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
